// File: rtl/outgoing_port_arbiter.sv
// Round-robin output port arbiter for one router output.
// Collects packets from all inputs into a single-entry valid/ready stage.

`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 4
`endif

module outgoing_port_arbiter #(
  parameter int NUM_INPUTS  = 5,
  parameter int NET_ADDR_W  = `NETWORK_ADDRESS_WIDTH,
  parameter int BANK_ADDR_W = `CACHE_BANK_ADDRESS_WIDTH,
  parameter int DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] reqValid,
  input  logic [NUM_INPUTS*(NET_ADDR_W+BANK_ADDR_W)-1:0]
                                reqDestinationAddress,
  input  logic [NUM_INPUTS*NET_ADDR_W-1:0]
                                reqRequesterAddress,
  input  logic [NUM_INPUTS-1:0] reqRead,
  input  logic [NUM_INPUTS-1:0] reqWrite,
  input  logic [NUM_INPUTS*DATA_W-1:0] reqData,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [NET_ADDR_W+BANK_ADDR_W-1:0]
                                outDestinationAddress,
  output logic [NET_ADDR_W-1:0] outRequesterAddress,
  output logic                  outRead,
  output logic                  outWrite,
  output logic [DATA_W-1:0]     outData,
  output logic [15:0]           packetCount
);

  localparam int DEST_W = NET_ADDR_W + BANK_ADDR_W;
  localparam int IDX_W  =
    (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [NET_ADDR_W-1:0] rqa_q, rqa_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                can_accept;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      cand;
  logic [DEST_W-1:0]   sel_dest;
  logic [NET_ADDR_W-1:0] sel_rqa;
  logic                sel_rd;
  logic                sel_wr;
  logic [DATA_W-1:0]   sel_data;
  logic                fire;
  logic                xfer;

  // Round-robin search starting just after the last winner.
  always_comb begin
    can_accept = (state_q == EMPTY) || outReady;
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_INPUTS))
        cand = cand - (IDX_W+1)'(NUM_INPUTS);
      if (!win_found && reqValid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // One-hot grant and winner field mux.
  always_comb begin
    grant    = '0;
    sel_dest = '0;
    sel_rqa  = '0;
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (win_idx == IDX_W'(i)) begin
        grant[i] = can_accept && win_found;
        sel_dest = reqDestinationAddress[i*DEST_W +: DEST_W];
        sel_rqa  = reqRequesterAddress[i*NET_ADDR_W +: NET_ADDR_W];
        sel_rd   = reqRead[i];
        sel_wr   = reqWrite[i];
        sel_data = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state: capture on grant, drain on accept, count transfers.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dest_d  = dest_q;
    rqa_d   = rqa_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    data_d  = data_q;
    fire    = |grant;
    xfer    = (state_q == FULL) && outReady;
    cnt_d   = cnt_q + {15'd0, xfer};
    unique case (state_q)
      EMPTY: if (fire) state_d = FULL;
      FULL:  if (outReady && !fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (fire) begin
      last_d = win_idx;
      dest_d = sel_dest;
      rqa_d  = sel_rqa;
      rd_d   = sel_rd;
      wr_d   = sel_wr;
      data_d = sel_data;
    end
  end

  // State and output stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      last_q  <= IDX_W'(NUM_INPUTS-1);
      dest_q  <= '0;
      rqa_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
      rqa_q   <= rqa_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign outValid              = (state_q == FULL);
  assign outDestinationAddress = dest_q;
  assign outRequesterAddress   = rqa_q;
  assign outRead               = rd_q;
  assign outWrite              = wr_q;
  assign outData               = data_q;
  assign packetCount           = cnt_q;

endmodule

// File: tb/tb_outgoing_port_arbiter.sv
// Randomized and directed bench for outgoing_port_arbiter.
// A transaction-level model predicts grants and the output stage.

module tb_outgoing_port_arbiter;

  localparam int N   = 5;
  localparam int NW  = 4;
  localparam int BW  = 4;
  localparam int DW  = 32;
  localparam int DSW = NW + BW;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     reqValid;
  logic [N*DSW-1:0] reqDestinationAddress;
  logic [N*NW-1:0]  reqRequesterAddress;
  logic [N-1:0]     reqRead;
  logic [N-1:0]     reqWrite;
  logic [N*DW-1:0]  reqData;
  logic [N-1:0]     grant;
  logic             outValid;
  logic             outReady;
  logic [DSW-1:0]   outDestinationAddress;
  logic [NW-1:0]    outRequesterAddress;
  logic             outRead;
  logic             outWrite;
  logic [DW-1:0]    outData;
  logic [15:0]      packetCount;

  outgoing_port_arbiter #(
    .NUM_INPUTS(N), .NET_ADDR_W(NW),
    .BANK_ADDR_W(BW), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid),
    .reqDestinationAddress(reqDestinationAddress),
    .reqRequesterAddress(reqRequesterAddress),
    .reqRead(reqRead), .reqWrite(reqWrite),
    .reqData(reqData), .grant(grant),
    .outValid(outValid), .outReady(outReady),
    .outDestinationAddress(outDestinationAddress),
    .outRequesterAddress(outRequesterAddress),
    .outRead(outRead), .outWrite(outWrite),
    .outData(outData), .packetCount(packetCount)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // pending packet held by each requester
  bit           p_v[N];
  logic [DSW-1:0] p_dst[N];
  logic [NW-1:0]  p_rqa[N];
  bit           p_rd[N];
  bit           p_wr[N];
  logic [DW-1:0]  p_dat[N];

  // model of the output stage
  bit           m_v;
  logic [DSW-1:0] m_dst;
  logic [NW-1:0]  m_rqa;
  bit           m_rd;
  bit           m_wr;
  logic [DW-1:0]  m_dat;
  logic [15:0]  m_cnt;
  int           m_last;
  logic [N-1:0] g_obs;
  int           gcount[N];

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_dst = '0; m_rqa = '0;
    m_rd = 0; m_wr = 0; m_dat = '0;
    m_cnt = '0; m_last = N - 1;
    for (int i = 0; i < N; i++) p_v[i] = 0;
  endtask

  task automatic new_pkt(int i);
    p_v[i]   = 1;
    p_dst[i] = DSW'($urandom);
    p_rqa[i] = NW'($urandom);
    p_rd[i]  = 1'($urandom);
    p_wr[i]  = 1'($urandom);
    p_dat[i] = $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      reqValid[i] = p_v[i];
      reqDestinationAddress[i*DSW +: DSW] = p_dst[i];
      reqRequesterAddress[i*NW +: NW] = p_rqa[i];
      reqRead[i]  = p_rd[i];
      reqWrite[i] = p_wr[i];
      reqData[i*DW +: DW] = p_dat[i];
    end
  endtask

  function automatic int pick();
    if (m_v && !outReady) return -1;
    for (int off = 1; off <= N; off++) begin
      int j;
      j = (m_last + off) % N;
      if (p_v[j]) return j;
    end
    return -1;
  endfunction

  // one clock: inputs set at negedge, returns at next negedge
  task automatic step();
    int w;
    drive();
    #1;
    w = pick();
    g_obs = grant;
    chk("grant", 64'(grant),
        (w < 0) ? 64'd0 : (64'd1 << w));
    @(posedge clk);
    if (m_v && outReady) m_cnt = m_cnt + 16'd1;
    if (w >= 0) begin
      m_v = 1; m_dst = p_dst[w]; m_rqa = p_rqa[w];
      m_rd = p_rd[w]; m_wr = p_wr[w]; m_dat = p_dat[w];
      m_last = w; p_v[w] = 0; gcount[w]++;
    end else if (m_v && outReady) begin
      m_v = 0;
    end
    #1;
    chk("outValid", 64'(outValid), 64'(m_v));
    chk("outDest", 64'(outDestinationAddress), 64'(m_dst));
    chk("outReqAddr", 64'(outRequesterAddress), 64'(m_rqa));
    chk("outRead", 64'(outRead), 64'(m_rd));
    chk("outWrite", 64'(outWrite), 64'(m_wr));
    chk("outData", 64'(outData), 64'(m_dat));
    chk("count", 64'(packetCount), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    drive();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int guard;
    reset = 1;
    outReady = 0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      p_dst[i] = '0; p_rqa[i] = '0; p_rd[i] = 0;
      p_wr[i] = 0; p_dat[i] = '0; gcount[i] = 0;
    end
    drive();
    #3;
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_count", 64'(packetCount), 64'd0);
    chk("rst_data", 64'(outData), 64'd0);
    @(negedge clk);
    reset = 0;

    // single packet from local input
    outReady = 1;
    new_pkt(0);
    p_dst[0] = 8'h2A;
    p_dat[0] = 32'hDEADBEEF;
    step();
    chk("t1_grant", 64'(g_obs), 64'd1);
    chk("t1_valid", 64'(outValid), 64'd1);
    chk("t1_data", 64'(outData), 64'hDEADBEEF);
    chk("t1_dest", 64'(outDestinationAddress), 64'h2A);
    step();
    chk("t1_count", 64'(packetCount), 64'd1);
    chk("t1_drain", 64'(outValid), 64'd0);

    // all inputs requesting: rotate 0..4,0,1
    do_reset();
    outReady = 1;
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < N; i++)
        if (!p_v[i]) new_pkt(i);
      step();
      chk("t2_seq", 64'(g_obs), 64'd1 << (k % N));
    end
    for (int i = 0; i < N; i++) p_v[i] = 0;
    step();
    chk("t2_count", 64'(packetCount), 64'd7);

    // stall with input 2 waiting
    new_pkt(1);
    step();
    outReady = 0;
    new_pkt(2);
    for (int k = 0; k < 4; k++) step();
    chk("t3_stall_g", 64'(g_obs), 64'd0);
    chk("t3_held", 64'(outValid), 64'd1);
    outReady = 1;
    step();
    chk("t3_g2", 64'(g_obs), 64'd4);

    // pointer wraps 3 -> 4 -> 0
    step();
    new_pkt(3);
    step();
    chk("t4_g3", 64'(g_obs), 64'd8);
    new_pkt(0);
    new_pkt(3);
    step();
    chk("t4_g0", 64'(g_obs), 64'd1);
    step();
    chk("t4_g3b", 64'(g_obs), 64'd8);

    // async reset while full and stalled
    new_pkt(0);
    step();
    outReady = 0;
    step();
    #2;
    reset = 1;
    #1;
    chk("t5_valid", 64'(outValid), 64'd0);
    chk("t5_count", 64'(packetCount), 64'd0);
    chk("t5_data", 64'(outData), 64'd0);
    @(negedge clk);
    reset = 0;
    model_reset();
    new_pkt(4);
    new_pkt(2);
    outReady = 1;
    step();
    chk("t5_first", 64'(g_obs), 64'd4);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      outReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!p_v[i] && $urandom_range(0, 1) == 1)
          new_pkt(i);
      step();
    end

    // fairness under saturation
    do_reset();
    outReady = 1;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int k = 0; k < 4 * N; k++) begin
      for (int i = 0; i < N; i++)
        if (!p_v[i]) new_pkt(i);
      step();
    end
    for (int i = 0; i < N; i++)
      chk("fair", 64'(gcount[i]), 64'd4);

    // counter wrap
    do_reset();
    outReady = 1;
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      if (!p_v[0]) new_pkt(0);
      step();
      guard++;
    end
    chk("wrap_reach", 64'(packetCount), 64'hFFFE);
    new_pkt(0);
    step();
    chk("wrap_ffff", 64'(packetCount), 64'hFFFF);
    new_pkt(0);
    step();
    chk("wrap_zero", 64'(packetCount), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/outgoing_port_arbiter.md
Name: outgoing_port_arbiter

Overview:
- One instance per router output port (local cache, north, south, east, west).
- Sits directly downstream of the five incoming port handlers and collects every packet whose port-select bit targets this output.
- Arbitrates among the requesters round-robin and registers the winning packet into a single-entry output stage.
- Drives the next router or the local cache over a valid/ready link, and stalls the losers until they are granted.

Parameters:
- NUM_INPUTS, 5, number of requesting input ports; index 0 = local, 1 = north, 2 = south, 3 = east, 4 = west.
- NET_ADDR_W, `NETWORK_ADDRESS_WIDTH, router address width.
- BANK_ADDR_W, `CACHE_BANK_ADDRESS_WIDTH, cache bank address width.
- DATA_W, 32, payload width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  NUM_INPUTS  per-input request; bit i = input i has a packet for this port.
- reqDestinationAddress  in  NUM_INPUTS*(NET_ADDR_W+BANK_ADDR_W)  packed, input i at slice i.
- reqRequesterAddress  in  NUM_INPUTS*NET_ADDR_W  packed.
- reqRead  in  NUM_INPUTS  read flag per input.
- reqWrite  in  NUM_INPUTS  write flag per input.
- reqData  in  NUM_INPUTS*DATA_W  packed payload.
- grant  out  NUM_INPUTS  combinational, one-hot or zero; bit i high = input i's packet is captured at this edge.
- outValid  out  1  output stage holds a packet.
- outReady  in  1  downstream accepts when outValid && outReady.
- outDestinationAddress  out  NET_ADDR_W+BANK_ADDR_W  registered.
- outRequesterAddress  out  NET_ADDR_W  registered.
- outRead  out  1  registered.
- outWrite  out  1  registered.
- outData  out  DATA_W  registered.
- packetCount  out  16  packets delivered downstream; wraps at 0xFFFF→0.

Behaviour:
- **Reset (async, immediate):**
  - outValid = 0; all out* payload fields = 0; grant = 0; packetCount = 0.
  - Round-robin pointer lastGrant = NUM_INPUTS-1, so input 0 has highest priority first.
  - Reset mid-hold discards the held packet; it is not delivered or counted.
- **Two states:**
  - EMPTY (outValid = 0) and FULL (outValid = 1).
  - canAccept = EMPTY || (FULL && outReady).
- **Arbitration (combinational):**
  - When canAccept, the winner is the first i with reqValid[i], searching lastGrant+1, lastGrant+2, … modulo NUM_INPUTS.
  - grant has exactly that bit set; grant = 0 when !canAccept or no request.
- **Capture at the edge where grant != 0:**
  - Winner's fields are loaded into the out* registers; outValid = 1; lastGrant = winner index.
  - lastGrant is unchanged when nothing is granted.
- **Requester obligations:**
  - A requester holds its reqValid and fields stable until it sees its grant bit.
  - It deasserts reqValid or presents the next packet in the following cycle.
- **Latency and throughput:**
  - Request captured at edge k → outValid visible in cycle k+1.
  - Throughput is 1 packet/cycle while outReady stays high (simultaneous drain and refill).
- **Drain:**
  - outValid && outReady && no grant → EMPTY, outValid = 0; payload registers hold their last value.
- **Stall:**
  - outValid && !outReady → all out* held, grant = 0, pointer frozen.
- **packetCount:**
  - Increments by 1 on every outValid && outReady edge.
  - Simultaneous drain+refill counts once.
  - Unsigned wrap-around.
- **Field integrity:**
  - outRead and outWrite copy the request flags verbatim, including a malformed both-set packet; no filtering.
- **Fairness:**
  - With all NUM_INPUTS requesting continuously, each input receives exactly one grant per NUM_INPUTS grants.

Test Plan:
- Reset, then reqValid=5'b00001 with dest=0x2A, data=0xDEADBEEF, outReady=1 → grant=00001 in that cycle; next cycle outValid=1, outData=0xDEADBEEF; packetCount=1 after the transfer edge.
- reqValid=5'b11111 held with fresh data each grant, outReady=1 → grant sequence 0,1,2,3,4,0,1; one packet/cycle; packetCount=7 after 7 transfers.
- Fill the stage, outReady=0 for 4 cycles with reqValid=5'b00100 → grant=0, out* stable, outValid=1; outReady=1 → input 2 granted on that same edge.
- After grant to input 3, reqValid=5'b01001 → next grant is input 0 (pointer 3 → 4 → 0), then input 3.
- Assert reset while FULL and outReady=0 → outValid=0 immediately without a clock edge; packetCount=0; first grant after release goes to the lowest-index requester.
- Preload packetCount near wrap (two transfers from 0xFFFE) → count reads 0xFFFF then 0x0000.
